// File: rtl/rotate_scheduler.sv
// Shared one-bit-per-cycle shift/rotate engine for two ALU requesters.
// Round-robin arbitration, iterative stepping, registered done pulse per requester.
module rotate_scheduler #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [CNT_W-1:0] b0,
    input  logic [CNT_W-1:0] b1,
    output logic             busy,
    output logic             grant_id,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result
);

    localparam logic [2:0] OP_ROR = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             last_served;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;

    logic             win;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [CNT_W-1:0] sel_b;
    logic [CNT_W-1:0] eff_n;
    logic [WIDTH-1:0] work_step;

    // One step of the selected operation; reserved ops leave the value untouched.
    function automatic logic [WIDTH-1:0] step(input logic [2:0] op, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        case (op)
            OP_ROR:  r = {v[0], v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Winner select: a tie goes to the requester not served last.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last_served;
        end else begin
            win = req1;
        end
        sel_op = win ? op1 : op0;
        sel_a  = win ? a1  : a0;
        sel_b  = win ? b1  : b0;
    end

    // Effective step count: rotates wrap, shifts saturate at WIDTH.
    always_comb begin
        eff_n = '0;
        case (sel_op)
            OP_ROR, OP_ROL:         eff_n = CNT_W'(sel_b % WIDTH_CNT);
            OP_SRL, OP_SLL, OP_SRA: eff_n = (sel_b > WIDTH_CNT) ? WIDTH_CNT : sel_b;
            default:                eff_n = '0;
        endcase
    end

    assign work_step = step(op_r, work);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            grant_id    <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            result      <= '0;
            last_served <= 1'b1;
            op_r        <= '0;
            work        <= '0;
            cnt         <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_id <= win;
                        op_r     <= sel_op;
                        work     <= sel_a;
                        cnt      <= eff_n;
                        busy     <= 1'b1;
                        if (eff_n != '0) begin
                            state <= RUN;
                        end else begin
                            state  <= DONE;
                            result <= sel_a;
                            done0  <= ~win;
                            done1  <= win;
                        end
                    end
                end
                RUN: begin
                    work <= work_step;
                    cnt  <= cnt - CNT_W'(1);
                    // Last step: publish the result alongside the done pulse.
                    if (cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        result <= work_step;
                        done0  <= ~grant_id;
                        done1  <= grant_id;
                    end
                end
                DONE: begin
                    last_served <= grant_id;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_scheduler.sv
// Directed self-checking bench for rotate_scheduler.
module tb_rotate_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, a1;
    logic [5:0]  b0, b1;
    logic        busy, grant_id, done0, done1;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    rotate_scheduler #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .a0(a0), .a1(a1),
        .b0(b0), .b1(b1),
        .busy(busy), .grant_id(grant_id),
        .done0(done0), .done1(done1),
        .result(result)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one request and wait (bounded) for its done; lat counts edges from acceptance edge = 1.
    task automatic do_op(input logic who, input logic [2:0] op, input logic [31:0] a,
                         input logic [5:0] b, input int drop_at,
                         output int lat, output logic [31:0] res, output logic wrong_done,
                         output logic gid_bad, output logic busy1);
        lat = -1; res = 32'hxxxxxxxx; wrong_done = 1'b0; gid_bad = 1'b0; busy1 = 1'b0;
        if (who) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else     begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (i == 1) busy1 = busy;
            if (i == drop_at) begin req0 = 1'b0; req1 = 1'b0; end
            if (busy && grant_id !== who) gid_bad = 1'b1;
            if ((who ? done0 : done1) !== 1'b0) wrong_done = 1'b1;
            if ((who ? done1 : done0) === 1'b1) begin
                lat = i;
                res = result;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL reset_grant: got %b want 0", grant_id); end
        total++; if (done0 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b%b want 00", done0, done1); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
    endtask

    task automatic test_ror();
        int lat; logic [31:0] res; logic wd, gb, b1s;
        do_op(1'b0, 3'b000, 32'h1, 6'd3, -1, lat, res, wd, gb, b1s);
        total++; if (b1s !== 1'b1) begin bad++; $display("FAIL ror_busy_rise: got %b want 1", b1s); end
        total++; if (lat != 4) begin bad++; $display("FAIL ror_latency: got %0d want 4", lat); end
        total++; if (res !== 32'h20000000) begin bad++; $display("FAIL ror_result: got %h want 20000000", res); end
        total++; if (wd !== 1'b0) begin bad++; $display("FAIL ror_done1_quiet: got %b want 0", wd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ror_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_rol();
        int lat; logic [31:0] res; logic wd, gb, b1s;
        do_op(1'b1, 3'b001, 32'h80000000, 6'd3, -1, lat, res, wd, gb, b1s);
        total++; if (lat != 4) begin bad++; $display("FAIL rol_latency: got %0d want 4", lat); end
        total++; if (res !== 32'h00000004) begin bad++; $display("FAIL rol_result: got %h want 00000004", res); end
        total++; if (gb !== 1'b0) begin bad++; $display("FAIL rol_grant_id: got bad=%b want 0", gb); end
        total++; if (wd !== 1'b0) begin bad++; $display("FAIL rol_done0_quiet: got %b want 0", wd); end
    endtask

    task automatic test_amounts();
        int lat; logic [31:0] res; logic wd, gb, b1s;
        do_op(1'b0, 3'b001, 32'h12345678, 6'd0, -1, lat, res, wd, gb, b1s);
        total++; if (lat != 1) begin bad++; $display("FAIL b0_latency: got %0d want 1", lat); end
        total++; if (res !== 32'h12345678) begin bad++; $display("FAIL b0_result: got %h want 12345678", res); end
        do_op(1'b1, 3'b000, 32'h1, 6'd35, -1, lat, res, wd, gb, b1s);
        total++; if (lat != 4) begin bad++; $display("FAIL ror35_latency: got %0d want 4", lat); end
        total++; if (res !== 32'h20000000) begin bad++; $display("FAIL ror35_result: got %h want 20000000", res); end
        do_op(1'b0, 3'b011, 32'hFFFFFFFF, 6'd40, -1, lat, res, wd, gb, b1s);
        total++; if (lat != 33) begin bad++; $display("FAIL sll40_latency: got %0d want 33", lat); end
        total++; if (res !== 32'h0) begin bad++; $display("FAIL sll40_result: got %h want 00000000", res); end
        do_op(1'b1, 3'b100, 32'h80000000, 6'd4, -1, lat, res, wd, gb, b1s);
        total++; if (lat != 5) begin bad++; $display("FAIL sra4_latency: got %0d want 5", lat); end
        total++; if (res !== 32'hF8000000) begin bad++; $display("FAIL sra4_result: got %h want f8000000", res); end
        do_op(1'b0, 3'b010, 32'h80000000, 6'd4, -1, lat, res, wd, gb, b1s);
        total++; if (res !== 32'h08000000) begin bad++; $display("FAIL srl4_result: got %h want 08000000", res); end
        do_op(1'b1, 3'b101, 32'hDEADBEEF, 6'd9, -1, lat, res, wd, gb, b1s);
        total++; if (lat != 1) begin bad++; $display("FAIL rsvd_latency: got %0d want 1", lat); end
        total++; if (res !== 32'hDEADBEEF) begin bad++; $display("FAIL rsvd_result: got %h want deadbeef", res); end
    endtask

    // Both requesters held from reset: grants alternate starting with 0, back-to-back.
    task automatic test_back_to_back();
        int k;
        logic [3:0]  who_seen;
        logic [31:0] res_seen [4];
        int          at_seen  [4];
        logic        both;
        logic [31:0] exp_res;
        k = 0; both = 1'b0; who_seen = 4'h0;
        for (int j = 0; j < 4; j++) begin res_seen[j] = 32'h0; at_seen[j] = -1; end
        reset = 1'b1;
        req0 = 1'b1; op0 = 3'b000; a0 = 32'h1; b0 = 6'd1;
        req1 = 1'b1; op1 = 3'b011; a1 = 32'h1; b1 = 6'd1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 40 && k < 4; i++) begin
            tick();
            if (done0 === 1'b1 && done1 === 1'b1) both = 1'b1;
            if (done0 === 1'b1 || done1 === 1'b1) begin
                who_seen[k] = done1;
                res_seen[k] = result;
                at_seen[k]  = i;
                k++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        total++; if (k != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", k); end
        total++; if (both !== 1'b0) begin bad++; $display("FAIL b2b_both_done: got %b want 0", both); end
        total++; if (who_seen !== 4'b1010) begin bad++; $display("FAIL b2b_order: got %b want 1010 (idx3..0)", who_seen); end
        for (int j = 0; j < 4; j++) begin
            exp_res = who_seen[j] ? 32'h00000002 : 32'h80000000;
            exp_res = (j % 2 == 1) ? 32'h00000002 : 32'h80000000;
            total++; if (res_seen[j] !== exp_res) begin bad++; $display("FAIL b2b_result%0d: got %h want %h", j, res_seen[j], exp_res); end
            total++; if (at_seen[j] != 2 + 3 * j) begin bad++; $display("FAIL b2b_timing%0d: got %0d want %0d", j, at_seen[j], 2 + 3 * j); end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; logic wd, gb, b1s;
        logic saw_done;
        saw_done = 1'b0;
        req0 = 1'b1; op0 = 3'b000; a0 = 32'h1; b0 = 6'd20;
        tick();
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1; req0 = 1'b0;
        tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL midrst_result: got %h want 00000000", result); end
        for (int i = 0; i < 30; i++) begin
            if (done0 === 1'b1 || done1 === 1'b1) saw_done = 1'b1;
            tick();
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL midrst_no_done: got %b want 0", saw_done); end
        do_op(1'b0, 3'b000, 32'h1, 6'd3, -1, lat, res, wd, gb, b1s);
        total++; if (lat != 4 || res !== 32'h20000000) begin bad++; $display("FAIL midrst_recover: got lat=%0d res=%h want lat=4 res=20000000", lat, res); end
    endtask

    task automatic test_drop();
        int lat; logic [31:0] res; logic wd, gb, b1s;
        do_op(1'b0, 3'b010, 32'hF0000000, 6'd8, 2, lat, res, wd, gb, b1s);
        total++; if (lat != 9) begin bad++; $display("FAIL drop_latency: got %0d want 9", lat); end
        total++; if (res !== 32'h00F00000) begin bad++; $display("FAIL drop_result: got %h want 00f00000", res); end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 3'b0; op1 = 3'b0;
        a0 = 32'h0; a1 = 32'h0;
        b0 = 6'd0; b1 = 6'd0;
        test_reset();
        test_ror();
        test_rol();
        test_amounts();
        test_back_to_back();
        test_reset_mid();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
